// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the MEM stage and a single-port,
// word-addressed data memory (combinational read, write on rising clk when WE).
// Loads take one READ cycle. SW takes one WRITE cycle. SB/SH read the word, merge
// the new lane and write it back. Illegal, misaligned or out-of-range requests
// finish immediately with an error and do not touch memory.
module lsu_mem_master #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] LP_ADDR_LIMIT = 32'(MEM_WORDS * 4);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]  r_state;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_a;
    logic [31:0] r_mem_wd;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_range;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    // Handshake and memory strobes decoded straight from the state, so an
    // asynchronous reset drops mem_we in the same instant.
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_DONE);
        mem_we     = (r_state == ST_WRITE);
        mem_a      = r_mem_a;
        mem_wd     = r_mem_wd;
        resp_rdata = r_rdata;
        resp_err   = r_err;
        w_accept   = req_valid && (r_state == ST_IDLE);
    end

    // Classify the incoming request: illegal funct3, misalignment, address range.
    always_comb begin
        if (req_we) begin
            w_illegal = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
        end else begin
            w_illegal = (req_funct3 != F3_B)  && (req_funct3 != F3_H) && (req_funct3 != F3_W) &&
                        (req_funct3 != F3_BU) && (req_funct3 != F3_HU);
        end
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_range    = (req_addr >= LP_ADDR_LIMIT);
        w_err      = w_illegal || w_misalign || w_range;
    end

    // Pick the addressed lane out of the word being read and extend it.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_funct3)
            F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    w_load_data = mem_rd;
            F3_BU:   w_load_data = {24'h0, w_byte};
            F3_HU:   w_load_data = {16'h0, w_half};
            default: w_load_data = '0;
        endcase
    end

    // Read-modify-write merge: replace the addressed byte or halfword lane.
    always_comb begin
        w_merge = mem_rd;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_lane)
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else begin
            if (r_lane[1]) begin
                w_merge[31:16] = r_wdata;
            end else begin
                w_merge[15:0]  = r_wdata;
            end
        end
    end

    // Request sequencing: IDLE -> (READ) -> (WRITE) -> DONE -> IDLE.
    // The merged or load word is captured at the end of READ, so the
    // registered mem_wd is already stable for the whole WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_lane   <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_mem_a  <= '0;
            r_mem_wd <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lane   <= req_addr[1:0];
                        r_funct3 <= req_funct3;
                        r_we     <= req_we;
                        r_wdata  <= req_wdata[15:0];
                        r_mem_a  <= {req_addr[31:2], 2'b00};
                        r_rdata  <= '0;
                        r_err    <= w_err;
                        if (w_err) begin
                            r_state <= ST_DONE;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            r_mem_wd <= req_wdata;
                            r_state  <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_we) begin
                        r_mem_wd <= w_merge;
                        r_state  <= ST_WRITE;
                    end else begin
                        r_rdata <= w_load_data;
                        r_state <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
